// File: rtl/exe_pkg.sv
// Shared opcode map, select encodings and the per-pass control word for the
// execute-stage sequencer.
package exe_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_PUSH = 5'b10000;
  localparam logic [OP_W-1:0] OP_POP  = 5'b10001;
  localparam logic [OP_W-1:0] OP_CALL = 5'b10010;
  localparam logic [OP_W-1:0] OP_RET  = 5'b10011;
  localparam logic [OP_W-1:0] OP_JAL  = 5'b10100;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11111;

  localparam logic [OP_W-1:0] ALU_ADD = 5'b00000;
  localparam logic [OP_W-1:0] ALU_SUB = 5'b00001;

  localparam logic [1:0] A_REG  = 2'b00;
  localparam logic [1:0] A_SP   = 2'b01;
  localparam logic [1:0] A_PC   = 2'b10;
  localparam logic [1:0] B_REG  = 2'b00;
  localparam logic [1:0] B_IMM  = 2'b01;
  localparam logic [1:0] B_FOUR = 2'b10;

  typedef struct packed {
    logic [OP_W-1:0] alu_op;
    logic [1:0]      a_sel;
    logic [1:0]      b_sel;
    logic            mem_in_sel;
    logic            sp_we;
    logic            link_we;
    logic            mem_we;
    logic            mem_re;
    logic            last;
  } ctrl_word_t;

  function automatic ctrl_word_t ctrl_idle();
    ctrl_word_t cw;
    cw = '0;
    cw.alu_op = ALU_ADD;
    cw.a_sel  = A_REG;
    cw.b_sel  = B_REG;
    return cw;
  endfunction

endpackage

// File: rtl/exe_ctrl_rom.sv
// Combinational control store: (opcode, pass index) -> control word, with the
// last-pass flag and undefined-opcode detection.
module exe_ctrl_rom
  import exe_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  input  logic [1:0]      pass,
  output ctrl_word_t      cw,
  output logic            illegal
);

  always_comb begin
    cw      = ctrl_idle();
    illegal = 1'b0;
    if (opcode[4:3] == 2'b00) begin
      cw.alu_op = opcode;
      cw.last   = 1'b1;
    end else if (opcode[4:3] == 2'b01) begin
      cw.alu_op = opcode;
      cw.b_sel  = B_IMM;
      cw.last   = 1'b1;
    end else begin
      case (opcode)
        OP_JAL: begin
          cw.a_sel   = A_PC;
          cw.b_sel   = B_FOUR;
          cw.link_we = 1'b1;
          cw.last    = 1'b1;
        end
        OP_NOP: cw.last = 1'b1;
        OP_PUSH: begin
          if (pass == 2'd0) begin
            cw.alu_op = ALU_SUB;
            cw.a_sel  = A_SP;
            cw.b_sel  = B_FOUR;
            cw.sp_we  = 1'b1;
          end else begin
            cw.mem_in_sel = 1'b1;
            cw.mem_we     = 1'b1;
            cw.last       = 1'b1;
          end
        end
        // RET pops the return address exactly like POP does.
        OP_POP, OP_RET: begin
          if (pass == 2'd0) begin
            cw.mem_in_sel = 1'b1;
            cw.mem_re     = 1'b1;
          end else begin
            cw.a_sel = A_SP;
            cw.b_sel = B_FOUR;
            cw.sp_we = 1'b1;
            cw.last  = 1'b1;
          end
        end
        OP_CALL: begin
          case (pass)
            2'd0: begin
              cw.alu_op = ALU_SUB;
              cw.a_sel  = A_SP;
              cw.b_sel  = B_FOUR;
              cw.sp_we  = 1'b1;
            end
            2'd1: begin
              cw.a_sel   = A_PC;
              cw.b_sel   = B_FOUR;
              cw.link_we = 1'b1;
            end
            default: begin
              cw.mem_in_sel = 1'b1;
              cw.mem_we     = 1'b1;
              cw.last       = 1'b1;
            end
          endcase
        end
        default: begin
          illegal = 1'b1;
          cw.last = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/exe_seq_ctrl.sv
// Execute-stage sequencer: holds the in-flight opcode and pass index, runs the
// decode handshake and applies stall gating to the control store output.
module exe_seq_ctrl
  import exe_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_opcode,
  input  logic           stall,
  output logic           pass_valid,
  output logic [OPW-1:0] alu_op,
  output logic [1:0]     alu_a_sel,
  output logic [1:0]     alu_b_sel,
  output logic           mem_in_sel,
  output logic           sp_we,
  output logic           link_we,
  output logic           mem_we,
  output logic           mem_re,
  output logic           out_valid,
  output logic           illegal
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;

  logic [0:0]     state;
  logic [OPW-1:0] op_q;
  logic [1:0]     pass_q;
  ctrl_word_t     cw;
  logic           rom_illegal;
  logic           exec;
  logic           accept;

  exe_ctrl_rom u_rom (
    .opcode  (OP_W'(op_q)),
    .pass    (pass_q),
    .cw      (cw),
    .illegal (rom_illegal)
  );

  assign exec     = (state == S_EXEC);
  // Reloading on a non-stalled last pass gives bubble-free back-to-back issue.
  assign in_ready = !rst && (!exec || (cw.last && !stall));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= '0;
      pass_q <= 2'd0;
    end else if (accept) begin
      state  <= S_EXEC;
      op_q   <= in_opcode;
      pass_q <= 2'd0;
    end else if (exec && !stall) begin
      if (cw.last) begin
        state  <= S_IDLE;
        pass_q <= 2'd0;
      end else begin
        pass_q <= pass_q + 2'd1;
      end
    end
  end

  // Register writes and completion are suppressed under stall; memory
  // requests stay up so the memory side sees a held request.
  assign pass_valid = exec;
  assign alu_op     = exec ? OPW'(cw.alu_op) : '0;
  assign alu_a_sel  = exec ? cw.a_sel : 2'b00;
  assign alu_b_sel  = exec ? cw.b_sel : 2'b00;
  assign mem_in_sel = exec && cw.mem_in_sel;
  assign sp_we      = exec && cw.sp_we && !stall;
  assign link_we    = exec && cw.link_we && !stall;
  assign mem_we     = exec && cw.mem_we;
  assign mem_re     = exec && cw.mem_re;
  assign out_valid  = exec && cw.last && !stall;
  assign illegal    = out_valid && rom_illegal;

endmodule

// File: tb/tb_exe_seq_ctrl.sv
// Scoreboard bench for exe_seq_ctrl: accepted opcodes expand into expected
// per-pass records that a negedge monitor retires against the DUT outputs.
module tb_exe_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_opcode = 5'b0;
  logic       stall = 1'b0;
  logic       pass_valid;
  logic [4:0] alu_op;
  logic [1:0] alu_a_sel, alu_b_sel;
  logic       mem_in_sel, sp_we, link_we, mem_we, mem_re, out_valid, illegal;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [4:0] aop;
    logic [1:0] a;
    logic [1:0] b;
    logic mis, sp, lk, mw, mr, last, ill;
  } pass_t;

  pass_t sb[$];
  logic  rst_prev = 1'b1;

  exe_seq_ctrl #(.OPW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .stall(stall), .pass_valid(pass_valid),
    .alu_op(alu_op), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .mem_in_sel(mem_in_sel), .sp_we(sp_we), .link_we(link_we),
    .mem_we(mem_we), .mem_re(mem_re), .out_valid(out_valid), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic pass_t mk(input logic [4:0] aop, input logic [1:0] a, input logic [1:0] b,
                               input logic mis, input logic sp, input logic lk, input logic mw,
                               input logic mr, input logic last, input logic ill);
    pass_t p;
    p = {aop, a, b, mis, sp, lk, mw, mr, last, ill};
    return p;
  endfunction

  // Reference: each instruction is a list of passes described directly from the ISA table.
  task automatic push_instr(input logic [4:0] op);
    if (op[4:3] == 2'b00) sb.push_back(mk(op, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0));
    else if (op[4:3] == 2'b01) sb.push_back(mk(op, 2'd0, 2'd1, 0, 0, 0, 0, 0, 1, 0));
    else if (op == 5'b10100) sb.push_back(mk(5'd0, 2'd2, 2'd2, 0, 0, 1, 0, 0, 1, 0));
    else if (op == 5'b11111) sb.push_back(mk(5'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0));
    else if (op == 5'b10000) begin
      sb.push_back(mk(5'd1, 2'd1, 2'd2, 0, 1, 0, 0, 0, 0, 0));
      sb.push_back(mk(5'd0, 2'd0, 2'd0, 1, 0, 0, 1, 0, 1, 0));
    end else if (op == 5'b10001 || op == 5'b10011) begin
      sb.push_back(mk(5'd0, 2'd0, 2'd0, 1, 0, 0, 0, 1, 0, 0));
      sb.push_back(mk(5'd0, 2'd1, 2'd2, 0, 1, 0, 0, 0, 1, 0));
    end else if (op == 5'b10010) begin
      sb.push_back(mk(5'd1, 2'd1, 2'd2, 0, 1, 0, 0, 0, 0, 0));
      sb.push_back(mk(5'd0, 2'd2, 2'd2, 0, 0, 1, 0, 0, 0, 0));
      sb.push_back(mk(5'd0, 2'd0, 2'd0, 1, 0, 0, 1, 0, 1, 0));
    end else sb.push_back(mk(5'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 1));
  endtask

  task automatic chk(input string name, input logic [16:0] got, input logic [16:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  logic [16:0] obs, expv;
  logic        exp_rdy;
  pass_t       e;

  always @(negedge clk) begin
    obs = {pass_valid, alu_op, alu_a_sel, alu_b_sel, mem_in_sel, sp_we, link_we,
           mem_we, mem_re, out_valid, illegal};
    if (rst) begin
      chk("ready_in_reset", {16'd0, in_ready}, 17'd0);
      if (rst_prev) chk("outputs_in_reset", obs, 17'd0);
      sb.delete();
    end else begin
      if (sb.size() == 0) expv = '0;
      else begin
        e = sb[0];
        expv = {1'b1, e.aop, e.a, e.b, e.mis, e.sp && !stall, e.lk && !stall,
                e.mw, e.mr, e.last && !stall, e.ill && e.last && !stall};
      end
      chk("controls", obs, expv);
      exp_rdy = (sb.size() == 0) || (sb.size() == 1 && !stall);
      chk("in_ready", {16'd0, in_ready}, {16'd0, exp_rdy});
      if (sb.size() != 0 && !stall) void'(sb.pop_front());
      if (in_valid && exp_rdy) push_instr(in_opcode);
    end
    rst_prev = rst;
  end

  task automatic drv(input logic r, input logic v, input logic [4:0] op, input logic st);
    @(posedge clk);
    #1;
    rst = r; in_valid = v; in_opcode = op; stall = st;
  endtask

  logic [4:0] special [7];

  initial begin
    special[0] = 5'b10000; special[1] = 5'b10001; special[2] = 5'b10010;
    special[3] = 5'b10011; special[4] = 5'b10100; special[5] = 5'b11111;
    special[6] = 5'b11000;
    repeat (3) drv(1, 0, 5'd0, 0);
    drv(0, 0, 5'd0, 0);
    // ADD then PUSH back to back
    drv(0, 1, 5'b00000, 0);
    drv(0, 1, 5'b10000, 0);
    drv(0, 0, 5'd0, 0);
    drv(0, 0, 5'd0, 0);
    drv(0, 0, 5'd0, 0);
    // CALL with two stall cycles on its store pass
    drv(0, 1, 5'b10010, 0);
    drv(0, 0, 5'd0, 0);
    drv(0, 0, 5'd0, 0);
    drv(0, 0, 5'd0, 1);
    drv(0, 0, 5'd0, 1);
    drv(0, 0, 5'd0, 0);
    drv(0, 0, 5'd0, 0);
    // POP chained into reg-imm
    drv(0, 1, 5'b10001, 0);
    drv(0, 0, 5'd0, 0);
    drv(0, 1, 5'b01010, 0);
    drv(0, 0, 5'd0, 0);
    // undefined opcode, issued while stall is high in IDLE
    drv(0, 1, 5'b11000, 1);
    drv(0, 0, 5'd0, 0);
    drv(0, 0, 5'd0, 0);
    // reset during CALL pass 1
    drv(0, 1, 5'b10010, 0);
    drv(0, 0, 5'd0, 0);
    drv(1, 0, 5'd0, 0);
    drv(1, 0, 5'd0, 0);
    drv(0, 0, 5'd0, 0);
    drv(0, 0, 5'd0, 0);
    for (int i = 0; i < 800; i++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 1) == 1) ? special[$urandom_range(0, 6)] : 5'($urandom);
      drv(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1), op,
          ($urandom_range(0, 3) == 0));
    end
    repeat (6) drv(0, 0, 5'd0, 0);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
